// File: rtl/mem_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_fifo_ctrl
//  Description : Valid/ready FIFO controller driving an external dual-address
//                memory with combinational read. Owns the write/read pointers
//                and the memory occupancy count, and adds a one-word
//                registered output stage in front of the consumer.
//
//  Parameters  : ADDR_LEN  - memory address width
//                WORD_SIZE - data width
//                MEM_SIZE  - memory depth in words (2 .. 2**ADDR_LEN)
//
//  Ports       : clk, rst (async, active-high), flush (sync clear)
//                push_valid/push_ready/push_data - producer side
//                pop_valid/pop_ready/pop_data    - consumer side (registered)
//                count/empty/full                - status, from registers only
//                mem_w_addr/mem_w_en/mem_data_in - memory write port
//                mem_r_addr/mem_r_en/mem_data_out- memory read port
//
//  Options     : `define MEM_FIFO_MONITOR_EN compiles in simulation-only
//                push/pop trace and consistency checks.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_fifo_ctrl #(
    parameter int ADDR_LEN  = 5,
    parameter int WORD_SIZE = 32,
    parameter int MEM_SIZE  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [WORD_SIZE-1:0]  push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [WORD_SIZE-1:0]  pop_data,
    output logic [ADDR_LEN:0]     count,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_LEN-1:0]   mem_w_addr,
    output logic                  mem_w_en,
    output logic [WORD_SIZE-1:0]  mem_data_in,
    output logic [ADDR_LEN-1:0]   mem_r_addr,
    output logic                  mem_r_en,
    input  logic [WORD_SIZE-1:0]  mem_data_out
);

    localparam logic [ADDR_LEN:0]   C_MEM_SIZE = (ADDR_LEN+1)'(MEM_SIZE);
    localparam logic [ADDR_LEN-1:0] C_LAST_PTR = ADDR_LEN'(MEM_SIZE - 1);

    logic [ADDR_LEN-1:0]  r_wr_ptr;
    logic [ADDR_LEN-1:0]  r_rd_ptr;
    logic [ADDR_LEN:0]    r_mem_cnt;
    logic                 r_out_valid;
    logic [WORD_SIZE-1:0] r_out_data;

    logic w_push_ready;
    logic w_push;
    logic w_pop;
    logic w_fetch;

    // Pointer increment with explicit wrap so non power-of-two depths work.
    function automatic logic [ADDR_LEN-1:0] f_next_ptr(input logic [ADDR_LEN-1:0] ptr);
        return (ptr == C_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // push_ready looks only at registered occupancy, never at pop_ready, so a
    // full FIFO only reopens in the cycle after a fetch has freed a slot.
    assign w_push_ready = !flush && (r_mem_cnt < C_MEM_SIZE);
    assign w_push       = push_valid && w_push_ready;
    assign w_pop        = r_out_valid && pop_ready;
    // Fetch needs a stored word, so it can never coincide with a write to the
    // same address (that would require mem_cnt == 0).
    assign w_fetch      = !flush && (r_mem_cnt != '0) && (!r_out_valid || w_pop);

    assign push_ready  = w_push_ready;
    assign mem_w_en    = w_push;
    assign mem_w_addr  = r_wr_ptr;
    assign mem_data_in = push_data;
    assign mem_r_en    = w_fetch;
    assign mem_r_addr  = r_rd_ptr;

    assign pop_valid = r_out_valid;
    assign pop_data  = r_out_data;
    assign count     = r_mem_cnt + (ADDR_LEN+1)'(r_out_valid);
    assign empty     = (r_mem_cnt == '0) && !r_out_valid;
    assign full      = (r_mem_cnt == C_MEM_SIZE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (flush) begin
            // A pop in this cycle still completes at the consumer; the
            // output stage is then simply dropped along with everything else.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_fetch) begin
                r_out_data  <= mem_data_out;
                r_out_valid <= 1'b1;
                r_rd_ptr    <= f_next_ptr(r_rd_ptr);
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            case ({w_push, w_fetch})
                2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
                2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
        end
    end

`ifdef MEM_FIFO_MONITOR_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (w_push) begin
                $display("[FIFO] push %0d %h", mem_w_addr, push_data);
            end
            if (w_pop) begin
                $display("[FIFO] pop %h", r_out_data);
            end
            if (r_mem_cnt > C_MEM_SIZE) begin
                $error("[FIFO] occupancy %0d exceeds depth %0d", r_mem_cnt, MEM_SIZE);
            end
            if (mem_w_en && mem_r_en && (mem_w_addr == mem_r_addr)) begin
                $error("[FIFO] simultaneous read and write at address %0d", mem_w_addr);
            end
        end
    end
`else
    // Monitor disabled: no simulation-only code.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_fifo_ctrl
//  Description : Self-checking bench for mem_fifo_ctrl. Drives a depth-32
//                instance through a vector table and directed sequences, and
//                a depth-20 instance through an odd-depth wrap sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_fifo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- depth-32 instance ----------------
    logic        flush, push_valid, push_ready, pop_valid, pop_ready;
    logic [31:0] push_data, pop_data, mem_data_in, mem_data_out;
    logic [5:0]  count;
    logic        empty, full, mem_w_en, mem_r_en;
    logic [4:0]  mem_w_addr, mem_r_addr;
    logic [31:0] mem_a [32];

    mem_fifo_ctrl #(.ADDR_LEN(5), .WORD_SIZE(32), .MEM_SIZE(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .count(count), .empty(empty), .full(full),
        .mem_w_addr(mem_w_addr), .mem_w_en(mem_w_en), .mem_data_in(mem_data_in),
        .mem_r_addr(mem_r_addr), .mem_r_en(mem_r_en), .mem_data_out(mem_data_out)
    );
    always @(posedge clk) if (mem_w_en) mem_a[mem_w_addr] <= mem_data_in;
    assign mem_data_out = mem_a[mem_r_addr];

    // ---------------- depth-20 instance ----------------
    logic        b_flush, b_push_valid, b_push_ready, b_pop_valid, b_pop_ready;
    logic [31:0] b_push_data, b_pop_data, b_mem_data_in, b_mem_data_out;
    logic [5:0]  b_count;
    logic        b_empty, b_full, b_mem_w_en, b_mem_r_en;
    logic [4:0]  b_mem_w_addr, b_mem_r_addr;
    logic [31:0] mem_b [32];

    mem_fifo_ctrl #(.ADDR_LEN(5), .WORD_SIZE(32), .MEM_SIZE(20)) dut20 (
        .clk(clk), .rst(rst), .flush(b_flush),
        .push_valid(b_push_valid), .push_ready(b_push_ready), .push_data(b_push_data),
        .pop_valid(b_pop_valid), .pop_ready(b_pop_ready), .pop_data(b_pop_data),
        .count(b_count), .empty(b_empty), .full(b_full),
        .mem_w_addr(b_mem_w_addr), .mem_w_en(b_mem_w_en), .mem_data_in(b_mem_data_in),
        .mem_r_addr(b_mem_r_addr), .mem_r_en(b_mem_r_en), .mem_data_out(b_mem_data_out)
    );
    always @(posedge clk) if (b_mem_w_en) mem_b[b_mem_w_addr] <= b_mem_data_in;
    assign b_mem_data_out = mem_b[b_mem_r_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        pv;
        logic [31:0] pd;
        logic        pr;
        logic        fl;
        logic        e_push_ready;
        logic        e_pop_valid;
        logic [31:0] e_pop_data;
        logic [5:0]  e_count;
        logic        e_empty;
        logic        e_full;
        logic        e_w_en;
        logic        e_r_en;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // Expected values are for the outputs seen during the cycle the inputs
        // are applied (state from the previous edges).
        //            pv  data          pr  fl   prdy pv  pop_data      cnt emp full wen ren
        vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        6'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        6'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h11,       1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 6'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'h22,       1'b1, 1'b0, 1'b1, 1'b1, 32'h11,       6'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'h33,       1'b0, 1'b0, 1'b1, 1'b0, 32'h11,       6'd1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h22,       6'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h22,       6'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        flush = 0; push_valid = 0; push_data = 0; pop_ready = 0;
        b_flush = 0; b_push_valid = 0; b_push_data = 0; b_pop_ready = 0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 0);
        @(negedge clk); rst = 0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            push_valid = vecs[i].pv; push_data = vecs[i].pd;
            pop_ready = vecs[i].pr; flush = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_push_ready", i), push_ready, vecs[i].e_push_ready);
            chk($sformatf("v%0d_pop_valid", i), pop_valid, vecs[i].e_pop_valid);
            chk($sformatf("v%0d_pop_data", i), pop_data, vecs[i].e_pop_data);
            chk($sformatf("v%0d_count", i), count, vecs[i].e_count);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
            chk($sformatf("v%0d_full", i), full, vecs[i].e_full);
            chk($sformatf("v%0d_w_en", i), mem_w_en, vecs[i].e_w_en);
            chk($sformatf("v%0d_r_en", i), mem_r_en, vecs[i].e_r_en);
        end

        // ---------------- asynchronous reset mid-operation ----------------
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); push_valid = 1; push_data = 32'h100 + i; pop_ready = 0; flush = 0;
        end
        @(negedge clk); push_valid = 0; #1;
        chk("pre_rst_count", count, 5);
        #1 rst = 1; #1;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_pop_valid", pop_valid, 0);
        chk("midrst_pop_data", pop_data, 0);
        chk("midrst_r_en", mem_r_en, 0);
        @(negedge clk); rst = 0; #1;
        chk("postrst_push_ready", push_ready, 1);

        // ---------------- fill to MEM_SIZE+1 ----------------
        begin
            int acc = 0;
            for (int c = 0; c < 80 && acc < 33; c++) begin
                @(negedge clk); push_valid = 1; push_data = acc; pop_ready = 0; #1;
                if (push_ready) acc++;
            end
            chk("fill_accepted", acc, 33);
        end
        @(negedge clk); push_valid = 0; #1;
        chk("fill_full", full, 1);
        chk("fill_push_ready", push_ready, 0);
        chk("fill_count", count, 33);
        chk("fill_pop_data", pop_data, 0);
        @(negedge clk); push_valid = 1; push_data = 32'hBAD; pop_ready = 1; #1;
        chk("full_pop_cycle_push_ready", push_ready, 0);
        @(negedge clk); push_valid = 0; pop_ready = 0; #1;
        chk("after_pop_push_ready", push_ready, 1);
        chk("after_pop_data", pop_data, 1);
        chk("after_pop_count", count, 32);

        // ---------------- flush with 10 words held ----------------
        @(negedge clk); flush = 1; #1;
        @(negedge clk); flush = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); push_valid = 1; push_data = 32'h200 + i;
        end
        @(negedge clk); push_valid = 0; #1;
        chk("preflush_count", count, 10);
        @(negedge clk); push_valid = 1; push_data = 32'hF00D; flush = 1; #1;
        chk("flush_w_en", mem_w_en, 0);
        chk("flush_r_en", mem_r_en, 0);
        chk("flush_push_ready", push_ready, 0);
        @(negedge clk); flush = 0; push_valid = 1; push_data = 32'hABC; #1;
        chk("postflush_count", count, 0);
        chk("postflush_empty", empty, 1);
        chk("postflush_w_en", mem_w_en, 1);
        chk("postflush_w_addr", mem_w_addr, 0);
        @(negedge clk); push_valid = 0; flush = 1;
        @(negedge clk); flush = 0;

        // ---------------- streaming wrap and order ----------------
        begin
            int pushed = 0, popped = 0, first_pop = -1, gaps = 0, errs = 0;
            logic [4:0] last_w = '0;
            bit had_w = 0, seen_wrap = 0;
            for (int c = 0; c < 300 && popped < 100; c++) begin
                @(negedge clk);
                push_valid = (pushed < 100); push_data = pushed; pop_ready = 1; #1;
                if (mem_w_en) begin
                    if (had_w && last_w == 5'd31 && mem_w_addr == 5'd0) seen_wrap = 1;
                    last_w = mem_w_addr; had_w = 1;
                end
                if (pop_valid) begin
                    if (pop_data !== 32'(popped)) errs++;
                    popped++;
                    if (first_pop < 0) first_pop = c;
                end else if (first_pop >= 0) begin
                    gaps++;
                end
                if (push_valid && push_ready) pushed++;
            end
            chk("stream_popped", popped, 100);
            chk("stream_order_errs", errs, 0);
            chk("stream_first_pop_cycle", first_pop, 2);
            chk("stream_gaps", gaps, 0);
            chk("stream_w_wrap", seen_wrap, 1);
        end
        @(negedge clk); push_valid = 0; pop_ready = 0; #1;
        chk("stream_end_empty", empty, 1);

        // ---------------- odd depth (MEM_SIZE = 20) ----------------
        begin
            int pushed = 0, popped = 0, errs = 0, bad_addr = 0;
            logic [4:0] last_w = '0;
            bit had_w = 0, seen_wrap = 0;
            for (int c = 0; c < 400 && popped < 50; c++) begin
                @(negedge clk);
                b_push_valid = (pushed < 50); b_push_data = 32'h5000 + pushed;
                // drain slower than fill for the first part so the FIFO fills up
                b_pop_ready = (c < 40) ? ((c % 4) == 0) : 1'b1;
                #1;
                if (b_mem_w_en) begin
                    if (b_mem_w_addr > 5'd19) bad_addr++;
                    if (had_w && last_w == 5'd19 && b_mem_w_addr == 5'd0) seen_wrap = 1;
                    last_w = b_mem_w_addr; had_w = 1;
                end
                if (b_mem_r_en && b_mem_r_addr > 5'd19) bad_addr++;
                if (b_pop_valid && b_pop_ready) begin
                    if (b_pop_data !== 32'h5000 + 32'(popped)) errs++;
                    popped++;
                end
                if (b_push_valid && b_push_ready) pushed++;
            end
            chk("odd_popped", popped, 50);
            chk("odd_order_errs", errs, 0);
            chk("odd_bad_addr", bad_addr, 0);
            chk("odd_w_wrap", seen_wrap, 1);
        end
        @(negedge clk); b_push_valid = 0; b_pop_ready = 0; #1;
        chk("odd_end_empty", b_empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_fifo_ctrl.md
# mem_fifo_ctrl

- Synchronous FIFO controller that initiates all accesses to a `MEMORY` instance (dual address, `r_en`/`w_en`, combinational read).
- Turns the memory into a valid/ready FIFO:
  - owns the write and read pointers and the occupancy count;
  - adds a one-word registered output stage so `pop_data` never depends combinationally on memory timing.
- Sits between a producer stage and a consumer stage in the datapath.
- The memory is a separate instance wired directly to the `mem_*` ports.

## Interface
Parameters:
- `ADDR_LEN`, 5, memory address width.
- `WORD_SIZE`, 32, data width.
- `MEM_SIZE`, 32, memory depth in words. Must satisfy 2 ≤ `MEM_SIZE` ≤ 2^`ADDR_LEN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `flush` in 1: synchronous clear.
- `push_valid` in 1: producer has a word.
- `push_ready` out 1: controller accepts a word this cycle.
- `push_data` in `WORD_SIZE`: producer word.
- `pop_valid` out 1: output stage holds a word.
- `pop_ready` in 1: consumer takes the word.
- `pop_data` out `WORD_SIZE`: output-stage word.
- `count` out `ADDR_LEN`+1: total words held (memory plus output stage).
- `empty` out 1: `count` == 0.
- `full` out 1: memory portion holds `MEM_SIZE` words.
- `mem_w_addr` out `ADDR_LEN`: write address.
- `mem_w_en` out 1: write enable.
- `mem_data_in` out `WORD_SIZE`: write data.
- `mem_r_addr` out `ADDR_LEN`: read address.
- `mem_r_en` out 1: read enable.
- `mem_data_out` in `WORD_SIZE`: read data; valid in the same cycle as `mem_r_addr`/`mem_r_en`.

## Operation
State:
- `wr_ptr`, `rd_ptr` (`ADDR_LEN` bits).
- `mem_cnt`, range 0..`MEM_SIZE`.
- `out_valid`, `out_data`.

Push:
- `push_ready` = !`flush` && `mem_cnt` < `MEM_SIZE`.
- push = `push_valid` && `push_ready`.
- `mem_w_en` = push, `mem_w_addr` = `wr_ptr`, `mem_data_in` = `push_data` (all combinational).
- On push, at the edge: `wr_ptr` advances.

Pop and fetch:
- pop = `pop_valid` && `pop_ready`.
- fetch = !`flush` && `mem_cnt` > 0 && (!`out_valid` || pop).
- `mem_r_en` = fetch, `mem_r_addr` = `rd_ptr`.
- On fetch, at the edge: `out_data` ← `mem_data_out`, `out_valid` ← 1, `rd_ptr` advances.
- On pop without fetch: `out_valid` ← 0.

Counters and wrap:
- `mem_cnt` ← `mem_cnt` + push − fetch.
- Pointer wrap: a pointer at `MEM_SIZE`−1 advances to 0. Not power-of-two modulo unless `MEM_SIZE` = 2^`ADDR_LEN`.
- `count` = `mem_cnt` + `out_valid`. Maximum is `MEM_SIZE`+1.

Required invariants:
- `push_ready` has no combinational path from `pop_ready`. A full FIFO accepts a push only in the cycle after a fetch frees a slot.
- Push and fetch in the same cycle with `mem_cnt` == 0 is impossible: fetch requires `mem_cnt` > 0. The write address and the read address are therefore never equal while both enables are high.
- Push and fetch in the same cycle leave `mem_cnt` unchanged.

Flush:
- When `flush` = 1: no push, no fetch, `mem_w_en` = `mem_r_en` = 0.
- At the edge: pointers ← 0, `mem_cnt` ← 0, `out_valid` ← 0.
- A pop in a flush cycle still completes at the consumer, then the data is discarded.

## Timing
Reset (asynchronous, immediate):
- `wr_ptr` = `rd_ptr` = 0, `mem_cnt` = 0, `out_valid` = 0, `out_data` = 0.
- Outputs: `pop_valid` = 0, `pop_data` = 0, `count` = 0, `empty` = 1, `full` = 0, `push_ready` = 1 (if `flush` = 0).
- `mem_w_en` = `mem_r_en` = 0 unless `push_valid` is high.
- Reset mid-operation discards all contents. No partial state survives.

Latency and throughput:
- Push-to-pop latency into an empty FIFO: a word pushed in cycle N is written at edge N. It is fetched in cycle N+1. `pop_valid` rises after edge N+1, i.e. it is visible in cycle N+2.
- Steady throughput is one push and one pop per cycle.

Registered vs combinational outputs:
- `pop_valid` and `pop_data` are registered.
- `full`, `empty` and `count` are derived from registers only.

## Configuration
`MEM_FIFO_MONITOR_EN`:
- **Defined:** simulation-only checks and trace are compiled in.
  - Each accepted push prints `[FIFO] push <addr> <data>`.
  - Each pop prints `[FIFO] pop <data>`.
  - `$error` fires if `mem_cnt` > `MEM_SIZE`.
  - `$error` fires if `mem_w_en` && `mem_r_en` && `mem_w_addr` == `mem_r_addr`.
- **Not defined:** no simulation code is compiled. Synthesized logic is identical in both cases.

## Test plan
- **Reset values:** assert `rst` mid-cycle with 5 words held → `count`=0, `empty`=1, `pop_valid`=0 immediately. `push_ready`=1 after release.
- **Single word:** push 0xDEADBEEF in cycle 0, `pop_ready`=0 → `pop_valid`=1 with `pop_data`=0xDEADBEEF from cycle 2; `count`=1 from cycle 1.
- **Fill:** push 33 words with `pop_ready`=0, `MEM_SIZE`=32.
  - After the 33rd accepted push: `full`=1, `push_ready`=0, `count`=33.
  - Asserting `pop_ready` for one cycle → `push_ready`=1 the following cycle.
- **Wrap and order:** stream 100 incrementing words with `push_valid`=`pop_ready`=1 → pops come out 0..99 in order, no gaps after the initial 2-cycle latency, and `mem_w_addr` wraps 31→0.
- **Odd depth:** `MEM_SIZE`=20, `ADDR_LEN`=5, push then pop 50 words → addresses wrap 19→0, never 20, and data order is preserved.
- **Flush:** flush with 10 words held while `push_valid`=1 → no write in the flush cycle; `count`=0, `empty`=1 next cycle; the next push is written at address 0.
